// File: rtl/gpio_irq_pkg.sv
// gpio_irq_pkg -- shared SoC register map constants for the GPIO blocks.
// Holds the GPIO port block word offsets and the GPIO interrupt block
// register offsets, both decoded from wb_adr_i[3:2]. It also holds the
// warm-up terminal count and a zero-extension helper for read data.
package gpio_irq_pkg;

   localparam int GPIO_MAX = 8;

   // GPIO port block word offsets (sits next to the interrupt block in the SoC map)
   localparam logic [1:0] GPIO_PORT_OUT_OFS = 2'd0;
   localparam logic [1:0] GPIO_PORT_DIR_OFS = 2'd1;
   localparam logic [1:0] GPIO_PORT_IN_OFS  = 2'd2;

   // GPIO interrupt block word offsets
   typedef enum logic [1:0] {
      IRQ_RISE_EN = 2'd0,
      IRQ_FALL_EN = 2'd1,
      IRQ_PENDING = 2'd2,
      IRQ_LEVEL   = 2'd3
   } irq_reg_e;

   // Edge detection is enabled once the warm-up counter reaches this value
   localparam logic [1:0] WARMUP_DONE = 2'd3;

   function automatic logic [31:0] zext8(input logic [GPIO_MAX-1:0] v);
      return {{(32-GPIO_MAX){1'b0}}, v};
   endfunction

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync -- per-vector two-flop synchronizer.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (both stages cleared)
//   d_i  : asynchronous input vector
//   q_o  : synchronized vector (second stage)
module gpio_sync #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] sync0_q;
   logic [W-1:0] sync1_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync0_q <= '0;
         sync1_q <= '0;
      end else begin
         sync0_q <= d_i;
         sync1_q <= sync0_q;
      end
   end

   assign q_o = sync1_q;

endmodule

// File: rtl/gpio_irq.sv
// gpio_irq -- GPIO edge interrupt controller with a Wishbone slave port.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   wb_stb_i/cyc_i : Wishbone strobe / cycle
//   wb_we_i        : write enable
//   wb_adr_i       : byte address, bits [3:2] select RISE_EN/FALL_EN/PENDING/LEVEL
//   wb_dat_i       : write data, bits [GPIO_NUM-1:0] used
//   wb_sel_i       : byte lanes, writes only land when lane 0 is selected
//   wb_dat_o       : read data, loaded together with ack
//   wb_ack_o       : one-cycle acknowledge
//   gpio_in        : asynchronous pad inputs
//   irq_o          : registered OR of PENDING
// Handshake: an access is taken when stb & cyc are high and ack is low; ack
// follows one cycle later for exactly one cycle, so a held strobe produces
// one access every two cycles.
module gpio_irq
   import gpio_irq_pkg::*;
#(
   parameter int GPIO_NUM = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   input  logic        wb_we_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   input  logic [7:0]  gpio_in,
   output logic        irq_o
);

   logic [GPIO_NUM-1:0] sync1;
   logic [GPIO_NUM-1:0] prev_q;
   logic [GPIO_NUM-1:0] rise_en_q;
   logic [GPIO_NUM-1:0] fall_en_q;
   logic [GPIO_NUM-1:0] pend_q, pend_d;
   logic [GPIO_NUM-1:0] rise_det, fall_det, clr;
   logic [1:0]          warm_q;
   logic                detect_en;
   logic                ack_q;
   logic [31:0]         dat_q;
   logic                irq_q;
   logic                req, wr_ok;
   irq_reg_e            reg_sel;
   logic [GPIO_MAX-1:0] rd8;
   logic [31:0]         rdata;
   logic                unused_bits;

   gpio_sync #(.W(GPIO_NUM)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (gpio_in[GPIO_NUM-1:0]),
      .q_o (sync1)
   );

   // prev keeps tracking sync1 during warm-up, so a pin already high at
   // reset release never looks like a rising edge once detection opens.
   assign detect_en = (warm_q == WARMUP_DONE);
   assign rise_det  = sync1 & ~prev_q & rise_en_q & {GPIO_NUM{detect_en}};
   assign fall_det  = ~sync1 & prev_q & fall_en_q & {GPIO_NUM{detect_en}};

   assign req     = wb_stb_i & wb_cyc_i & ~ack_q;
   assign wr_ok   = req & wb_we_i & wb_sel_i[0];
   assign reg_sel = irq_reg_e'(wb_adr_i[3:2]);

   // W1C clear is applied first so a coincident new edge wins
   assign clr    = (wr_ok && reg_sel == IRQ_PENDING) ? wb_dat_i[GPIO_NUM-1:0] : '0;
   assign pend_d = (pend_q & ~clr) | rise_det | fall_det;

   always_comb begin
      rd8 = '0;
      case (reg_sel)
         IRQ_RISE_EN: rd8[GPIO_NUM-1:0] = rise_en_q;
         IRQ_FALL_EN: rd8[GPIO_NUM-1:0] = fall_en_q;
         IRQ_PENDING: rd8[GPIO_NUM-1:0] = pend_q;
         IRQ_LEVEL:   rd8[GPIO_NUM-1:0] = sync1;
         default:     rd8 = '0;
      endcase
      rdata = zext8(rd8);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q    <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         pend_q    <= '0;
         warm_q    <= '0;
         ack_q     <= 1'b0;
         dat_q     <= '0;
         irq_q     <= 1'b0;
      end else begin
         prev_q <= sync1;
         pend_q <= pend_d;
         irq_q  <= |pend_q;
         ack_q  <= req;
         if (!detect_en) begin
            warm_q <= warm_q + 2'd1;
         end
         if (req && !wb_we_i) begin
            dat_q <= rdata;
         end
         if (wr_ok) begin
            case (reg_sel)
               IRQ_RISE_EN: rise_en_q <= wb_dat_i[GPIO_NUM-1:0];
               IRQ_FALL_EN: fall_en_q <= wb_dat_i[GPIO_NUM-1:0];
               default: ;  // PENDING handled via clr, LEVEL is read-only
            endcase
         end
      end
   end

   assign wb_ack_o = ack_q;
   assign wb_dat_o = dat_q;
   assign irq_o    = irq_q;

   // Address/data/lane bits that the register map does not decode
   assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i, wb_sel_i[3:1], gpio_in};

endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq -- self-checking bench for gpio_irq.
// A reference model built from sampled input history predicts irq_o,
// wb_ack_o and wb_dat_o every cycle; directed tables and sequences cover
// register access, edge timing, W1C races, warm-up and reset corners.
module tb_gpio_irq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
   logic [31:0] adr = '0, wdat = '0;
   logic [3:0]  sel = '0;
   logic [31:0] dat_o;
   logic        ack;
   logic [7:0]  gpio = '0;
   logic        irq;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   gpio_irq #(.GPIO_NUM(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .wb_stb_i (stb),
      .wb_cyc_i (cyc),
      .wb_we_i  (we),
      .wb_adr_i (adr),
      .wb_dat_i (wdat),
      .wb_sel_i (sel),
      .wb_dat_o (dat_o),
      .wb_ack_o (ack),
      .gpio_in  (gpio),
      .irq_o    (irq)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // a1/a2/a3 = gpio_in as sampled 1/2/3 clock edges ago. An edge seen two
   // samples back versus three samples back is a detected pin edge, allowed
   // from the fourth edge after reset release.
   logic [7:0]  m_rise = '0, m_fall = '0, m_pend = '0;
   logic [7:0]  a1 = '0, a2 = '0, a3 = '0;
   logic        m_ack = 1'b0, m_irq = 1'b0;
   logic [31:0] m_dat = '0;
   int          m_edges = 0;
   bit          model_ok = 1'b0;

   always @(posedge clk) begin : model
      logic [7:0] rise, fall, clr;
      logic       req;
      if (rst) begin
         m_rise = '0; m_fall = '0; m_pend = '0;
         a1 = '0; a2 = '0; a3 = '0;
         m_ack = 1'b0; m_irq = 1'b0; m_dat = '0;
         m_edges = 0;
         model_ok = 1'b1;
      end else begin
         if (m_edges < 100) m_edges++;
         rise = '0;
         fall = '0;
         if (m_edges >= 4) begin
            rise = a2 & ~a3 & m_rise;
            fall = ~a2 & a3 & m_fall;
         end
         req = stb && cyc && !m_ack;
         clr = '0;
         if (req && !we) begin
            case (adr[3:2])
               2'd0: m_dat = {24'b0, m_rise};
               2'd1: m_dat = {24'b0, m_fall};
               2'd2: m_dat = {24'b0, m_pend};
               default: m_dat = {24'b0, a2};
            endcase
         end
         if (req && we && sel[0]) begin
            case (adr[3:2])
               2'd0: m_rise = wdat[7:0];
               2'd1: m_fall = wdat[7:0];
               2'd2: clr = wdat[7:0];
               default: ;
            endcase
         end
         m_irq  = (m_pend != 8'h00);
         m_pend = (m_pend & ~clr) | rise | fall;
         m_ack  = req;
         a3 = a2;
         a2 = a1;
         a1 = gpio;
      end
   end

   // Cycle-by-cycle output comparison against the model
   always @(negedge clk) begin
      if (model_ok) begin
         check("cyc_irq",   {31'b0, irq}, {31'b0, m_irq});
         check("cyc_ack",   {31'b0, ack}, {31'b0, m_ack});
         check("cyc_dat_o", dat_o, m_dat);
      end
   end

   // ---------------- driver tasks ----------------
   function automatic logic [31:0] mk_adr(input logic [1:0] ofs);
      return 32'hABCD_EF00 | {28'b0, ofs, 2'b11};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge where ack was seen
   task automatic wb_xfer(input logic [1:0] ofs, input logic w, input logic [3:0] s,
                          input logic [31:0] d, output logic [31:0] rd);
      int t;
      adr = mk_adr(ofs); we = w; sel = s; wdat = d; stb = 1'b1; cyc = 1'b1;
      for (t = 0; t < 8; t++) begin
         @(negedge clk);
         if (ack) break;
      end
      check("wb_ack_seen", {31'b0, ack}, 32'd1);
      rd = dat_o;
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
   endtask

   task automatic wb_write(input logic [1:0] ofs, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] dummy;
      wb_xfer(ofs, 1'b1, s, d, dummy);
   endtask

   task automatic wb_read(input logic [1:0] ofs, output logic [31:0] rd);
      wb_xfer(ofs, 1'b0, 4'hF, 32'h0, rd);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [1:0]  ofs;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
   } vec_t;
   vec_t vecs[7];

   initial begin : watchdog
      #2_000_000;
      n_errors++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin : stim
      logic [31:0] rd;
      logic [3:0]  pat;
      int          r;

      vecs[0] = '{2'd0, 4'b0010, 32'hFFFF_FFFF, 32'h0000_0000};  // lane 0 off: ignored
      vecs[1] = '{2'd0, 4'b0001, 32'h0000_00A5, 32'h0000_00A5};
      vecs[2] = '{2'd1, 4'b1111, 32'hFFFF_FF3C, 32'h0000_003C};  // upper bits read 0
      vecs[3] = '{2'd3, 4'b1111, 32'h0000_00FF, 32'h0000_0000};  // LEVEL is read-only
      vecs[4] = '{2'd0, 4'b0001, 32'h0000_0000, 32'h0000_0000};
      vecs[5] = '{2'd1, 4'b0001, 32'h0000_0000, 32'h0000_0000};
      vecs[6] = '{2'd2, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000};

      // reset state
      tick(3);
      check("rst_irq", {31'b0, irq}, 32'd0);
      check("rst_ack", {31'b0, ack}, 32'd0);
      check("rst_dat", dat_o, 32'd0);
      rst = 1'b0;
      tick(4);

      // register access table
      for (int i = 0; i < 7; i++) begin
         wb_write(vecs[i].ofs, vecs[i].wdata, vecs[i].sel);
         exp_q.push_back(vecs[i].exp_rd);
         wb_read(vecs[i].ofs, rd);
         check($sformatf("table%0d", i), rd, exp_q.pop_front());
      end

      // rising edge on pin 0: pending two edges later, irq one after that
      wb_write(2'd0, 32'h01, 4'hF);
      gpio = 8'h01;
      tick(1); check("rise_irq_k",   {31'b0, irq}, 32'd0);
      tick(1); check("rise_irq_k1",  {31'b0, irq}, 32'd0);
      tick(1); check("rise_irq_k2",  {31'b0, irq}, 32'd0);
      tick(1); check("rise_irq_k3",  {31'b0, irq}, 32'd1);
      wb_read(2'd2, rd); check("rise_pend", rd, 32'h01);
      wb_write(2'd2, 32'h01, 4'hF);
      wb_read(2'd2, rd); check("rise_clr", rd, 32'h00);

      // falling edge on pin 7, then W1C
      wb_write(2'd1, 32'h80, 4'hF);
      gpio = 8'h81; tick(5);
      gpio = 8'h01; tick(5);
      wb_read(2'd2, rd); check("fall_pend", rd, 32'h80);
      check("fall_irq", {31'b0, irq}, 32'd1);
      wb_write(2'd2, 32'h80, 4'hF);
      tick(1); check("fall_irq_clr", {31'b0, irq}, 32'd0);
      wb_read(2'd2, rd); check("fall_pend_clr", rd, 32'h00);

      // W1C coinciding with a new edge on the same bit: set wins
      wb_write(2'd0, 32'h02, 4'hF);
      gpio = 8'h03; tick(4);
      wb_read(2'd2, rd); check("race_pre", rd, 32'h02);
      gpio = 8'h01; tick(4);
      gpio = 8'h03; tick(2);
      wb_write(2'd2, 32'h02, 4'hF);
      wb_read(2'd2, rd); check("race_setwins", rd, 32'h02);
      wb_write(2'd0, 32'h00, 4'hF);
      wb_read(2'd2, rd); check("en_clr_keeps", rd, 32'h02);
      wb_write(2'd2, 32'h02, 4'hF);
      wb_read(2'd2, rd); check("race_clr", rd, 32'h00);

      // held strobe on LEVEL read
      gpio = 8'h5A; tick(4);
      pat = 4'b1010;
      adr = mk_adr(2'd3); we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
      check("hold_ack0", {31'b0, ack}, 32'd0);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("hold_ack%0d", i), {31'b0, ack}, {31'b0, pat[i]});
         if (pat[i]) check($sformatf("hold_dat%0d", i), dat_o, 32'h5A);
      end
      stb = 1'b0; cyc = 1'b0;
      tick(2);

      // reset during a transfer, with pins high through reset release
      gpio = 8'hFF;
      adr = mk_adr(2'd1); we = 1'b1; sel = 4'hF; wdat = 32'hFF; stb = 1'b1; cyc = 1'b1;
      rst = 1'b1;
      tick(1); check("rst_mid_ack", {31'b0, ack}, 32'd0);
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      tick(2);
      rst = 1'b0;
      wb_write(2'd0, 32'hFF, 4'hF);
      tick(6);
      check("warm_irq", {31'b0, irq}, 32'd0);
      wb_read(2'd2, rd); check("warm_pend", rd, 32'h00);
      wb_read(2'd1, rd); check("rst_mid_fall_en", rd, 32'h00);

      // randomized traffic, checked cycle-by-cycle against the model
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         if (r <= 2) begin
            gpio = 8'($urandom);
            tick(1);
         end else if (r <= 5) begin
            wb_write(2'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)));
         end else if (r <= 8) begin
            wb_read(2'($urandom_range(0, 3)), rd);
         end else begin
            tick($urandom_range(1, 3));
         end
      end

      tick(4);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
